range_echo_writer: RTL and testbench

Producer side of the range-sensor measurement FIFO. Fires the ultrasonic trigger pulse, times the returning echo, and converts the echo width to a distance count. Pushes one word per measurement into the FWFT FIFO's write port (`wr`/`wr_data`/`full`), which the controller's readers then drain. Sits between the sensor pins and the FIFO inside the range-sensor controller.

---
 rtl/range_echo_writer.sv | 210 +++++++++++++++++++++
 tb/tb_range_echo_writer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/range_echo_writer.sv
// range_echo_writer: producer side of the range-sensor measurement FIFO.
// Fires the trigger pulse, times the echo, converts the echo width to a
// distance count and pushes one word per measurement into the FIFO.
// Build option: define RANGE_ECHO_SYNC_EN to put a 2-flop synchronizer on
// the echo pin (adds 2 cycles of latency to every echo-driven transition).
module range_echo_writer #(
    parameter int DATA_WIDTH     = 16,
    parameter int TRIG_CYCLES    = 1000,
    parameter int DIV_CYCLES     = 5800,
    parameter int TIMEOUT_CYCLES = 3_800_000,
    parameter int HOLDOFF_CYCLES = 6_000_000
) (
    input  logic                  clk,
    input  logic                  rs,
    input  logic                  start,
    input  logic                  en,
    input  logic                  echo,
    input  logic                  full,
    output logic                  trig,
    output logic                  wr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  drop,
    output logic [7:0]            drop_cnt
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        PUSH      = 3'd4,
        HOLDOFF   = 3'd5
    } state_t;

    // All-ones marks a timeout, so real distances stop one below it.
    localparam logic [DATA_WIDTH-1:0] DIST_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DIST_MAX  = {{(DATA_WIDTH-1){1'b1}}, 1'b0};

    state_t                state_r, state_s;
    logic [31:0]           cnt_r, cnt_s;      // trigger / holdoff counter
    logic [31:0]           tmo_r, tmo_s;      // cycles since trigger fall
    logic [31:0]           sub_r, sub_s;      // echo cycles within one unit
    logic [DATA_WIDTH-1:0] dist_r, dist_s;
    logic [DATA_WIDTH-1:0] result_r, result_s;
    logic                  trig_s, wr_s, busy_s, drop_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic [7:0]            drop_cnt_s;
    logic                  echo_s;
    logic                  timeout_s;
    logic [31:0]           tick_sub_s;
    logic [DATA_WIDTH-1:0] tick_dist_s;

`ifdef RANGE_ECHO_SYNC_EN
    logic [1:0] sync_r;

    // Two-flop synchronizer for the asynchronous echo pin.
    always_ff @(posedge clk) begin
        if (rs) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], echo};
        end
    end

    assign echo_s = sync_r[1];
`else
    assign echo_s = echo;
`endif

    // One echo-high cycle: advance the sub-divider, bump distance on wrap.
    always_comb begin
        tick_sub_s  = sub_r + 32'd1;
        tick_dist_s = dist_r;
        if (sub_r >= 32'(DIV_CYCLES - 1)) begin
            tick_sub_s = 32'd0;
            if (dist_r != DIST_MAX) begin
                tick_dist_s = dist_r + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                tick_dist_s = dist_r;
            end
        end else begin
            tick_sub_s = sub_r + 32'd1;
        end
    end

    // The timeout counter starts at 1 on trigger fall, so it reads
    // TIMEOUT_CYCLES-1 on the last allowed cycle.
    assign timeout_s = (tmo_r >= 32'(TIMEOUT_CYCLES - 1));

    // Next-state, counter and output-next logic.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        tmo_s      = tmo_r;
        sub_s      = sub_r;
        dist_s     = dist_r;
        result_s   = result_r;
        case (state_r)
            IDLE: begin
                if (start || en) begin
                    state_s = TRIG;
                    cnt_s   = 32'd0;
                    tmo_s   = 32'd0;
                    sub_s   = 32'd0;
                    dist_s  = {DATA_WIDTH{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            TRIG: begin
                if (cnt_r >= 32'(TRIG_CYCLES - 1)) begin
                    state_s = WAIT_RISE;
                    tmo_s   = 32'd1;
                end else begin
                    cnt_s = cnt_r + 32'd1;
                end
            end
            WAIT_RISE: begin
                if (echo_s) begin
                    // The rising cycle is itself the first echo-high cycle.
                    state_s = MEASURE;
                    sub_s   = tick_sub_s;
                    dist_s  = tick_dist_s;
                    tmo_s   = tmo_r + 32'd1;
                end else if (timeout_s) begin
                    state_s  = PUSH;
                    result_s = DIST_ONES;
                end else begin
                    tmo_s = tmo_r + 32'd1;
                end
            end
            MEASURE: begin
                // Echo fall takes priority over a timeout on the same cycle.
                if (!echo_s) begin
                    state_s  = PUSH;
                    result_s = dist_r;
                end else if (timeout_s) begin
                    state_s  = PUSH;
                    result_s = DIST_ONES;
                end else begin
                    sub_s  = tick_sub_s;
                    dist_s = tick_dist_s;
                    tmo_s  = tmo_r + 32'd1;
                end
            end
            PUSH: begin
                state_s = HOLDOFF;
                cnt_s   = 32'd0;
            end
            HOLDOFF: begin
                if (cnt_r >= 32'(HOLDOFF_CYCLES - 1)) begin
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r + 32'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        trig_s = (state_s == TRIG);
        busy_s = (state_s != IDLE);
        wr_s   = (state_r == PUSH) && !full;
        drop_s = (state_r == PUSH) && full;
        if (wr_s) begin
            wr_data_s = result_r;
        end else begin
            wr_data_s = wr_data;
        end
        if (drop_s && (drop_cnt != 8'hFF)) begin
            drop_cnt_s = drop_cnt + 8'd1;
        end else begin
            drop_cnt_s = drop_cnt;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rs) begin
            state_r  <= IDLE;
            cnt_r    <= 32'd0;
            tmo_r    <= 32'd0;
            sub_r    <= 32'd0;
            dist_r   <= {DATA_WIDTH{1'b0}};
            result_r <= {DATA_WIDTH{1'b0}};
            trig     <= 1'b0;
            wr       <= 1'b0;
            wr_data  <= {DATA_WIDTH{1'b0}};
            busy     <= 1'b0;
            drop     <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            tmo_r    <= tmo_s;
            sub_r    <= sub_s;
            dist_r   <= dist_s;
            result_r <= result_s;
            trig     <= trig_s;
            wr       <= wr_s;
            wr_data  <= wr_data_s;
            busy     <= busy_s;
            drop     <= drop_s;
            drop_cnt <= drop_cnt_s;
        end
    end

endmodule

// File: tb/tb_range_echo_writer.sv
// Directed testbench for range_echo_writer (DATA_WIDTH=8, TRIG_CYCLES=4,
// DIV_CYCLES=10, TIMEOUT_CYCLES=200, HOLDOFF_CYCLES=8). A second instance
// with TIMEOUT_CYCLES=5000 covers distance saturation.
module tb_range_echo_writer;

`ifdef RANGE_ECHO_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rs = 1'b1;
    logic       start = 1'b0;
    logic       en = 1'b0;
    logic       echo = 1'b0;
    logic       full = 1'b0;
    logic       trig, wr, busy, drop;
    logic [7:0] wr_data, drop_cnt;

    logic       start_sat = 1'b0;
    logic       trig_sat, wr_sat, busy_sat, drop_sat;
    logic [7:0] wr_data_sat, drop_cnt_sat;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    range_echo_writer #(
        .DATA_WIDTH(8), .TRIG_CYCLES(4), .DIV_CYCLES(10),
        .TIMEOUT_CYCLES(200), .HOLDOFF_CYCLES(8)
    ) dut (
        .clk(clk), .rs(rs), .start(start), .en(en), .echo(echo), .full(full),
        .trig(trig), .wr(wr), .wr_data(wr_data), .busy(busy), .drop(drop),
        .drop_cnt(drop_cnt)
    );

    range_echo_writer #(
        .DATA_WIDTH(8), .TRIG_CYCLES(4), .DIV_CYCLES(10),
        .TIMEOUT_CYCLES(5000), .HOLDOFF_CYCLES(8)
    ) dut_sat (
        .clk(clk), .rs(rs), .start(start_sat), .en(1'b0), .echo(echo), .full(1'b0),
        .trig(trig_sat), .wr(wr_sat), .wr_data(wr_data_sat), .busy(busy_sat),
        .drop(drop_sat), .drop_cnt(drop_cnt_sat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One measurement: trigger (by start or by en), echo high for `width`
    // cycles after trigger fall (0 = no echo), then wait for wr/drop and
    // for busy to fall. lat counts cycles from echo fall (or trigger fall
    // when there is no echo) to the wr/drop pulse.
    task automatic measure(input bit use_start, input int width,
                           output int trig_len, output int lat, output int ev,
                           output logic [7:0] data, output logic after, output int hold);
        int b;
        if (use_start) begin
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        b = 0;
        while (!trig && b < 50) begin
            tick();
            b++;
        end
        trig_len = 0;
        while (trig && trig_len < 20) begin
            tick();
            trig_len++;
        end
        if (width > 0) begin
            echo = 1'b1;
            repeat (width) tick();
            echo = 1'b0;
        end
        lat = 0;
        while (!wr && !drop && lat < 400) begin
            tick();
            lat++;
        end
        ev   = wr ? 1 : (drop ? 2 : 0);
        data = wr_data;
        tick();
        after = wr | drop;
        hold  = 1;
        while (busy && hold < 50) begin
            tick();
            hold++;
        end
    endtask

    initial begin
        int tl, lat, ev, hold, b, n_wr, n_drop, n_after;
        logic [7:0] data;
        logic after;

        // Reset state.
        rs = 1'b1;
        repeat (3) tick();
        rs = 1'b0;
        tick();
        check("rst_trig", trig, 0);
        check("rst_wr", wr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop, 0);
        check("rst_drop_cnt", drop_cnt, 0);

        // Basic one-shot: 57-cycle echo -> distance 5.
        measure(1'b1, 57, tl, lat, ev, data, after, hold);
        check("basic_trig_len", tl, 4);
        check("basic_event_wr", ev, 1);
        check("basic_data", data, 5);
        check("basic_latency", lat, 2 + LAT);
        check("basic_wr_one_cycle", after, 0);
        check("basic_holdoff", hold, 8);
        check("basic_wr_data_hold", wr_data, 5);

        // Short echo under one unit truncates to 0; a 10-cycle echo gives 1.
        measure(1'b1, 9, tl, lat, ev, data, after, hold);
        check("trunc9_data", data, 0);
        measure(1'b1, 10, tl, lat, ev, data, after, hold);
        check("exact10_data", data, 1);

        // No echo: all-ones written 200 cycles after trigger fall.
        measure(1'b1, 0, tl, lat, ev, data, after, hold);
        check("noecho_event_wr", ev, 1);
        check("noecho_data", data, 8'hFF);
        check("noecho_latency", lat, 200);

        // Timeout boundary: echo falling on the last allowed cycle wins.
        measure(1'b1, 198 - LAT, tl, lat, ev, data, after, hold);
        check("boundary_echo_wins", data, 19);
        measure(1'b1, 199 - LAT, tl, lat, ev, data, after, hold);
        check("boundary_timeout", data, 8'hFF);

        // Saturation on the long-timeout instance: 3000 cycles -> 0xFE.
        start_sat = 1'b1;
        tick();
        start_sat = 1'b0;
        b = 0;
        while (trig_sat && b < 20) begin
            tick();
            b++;
        end
        echo = 1'b1;
        repeat (3000) tick();
        echo = 1'b0;
        b = 0;
        while (!wr_sat && b < 20) begin
            tick();
            b++;
        end
        check("sat_wr_seen", wr_sat, 1);
        check("sat_data", wr_data_sat, 8'hFE);
        repeat (12) tick();

        // Continuous mode: 25-cycle echoes -> back-to-back writes of 2.
        en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            measure(1'b0, 25, tl, lat, ev, data, after, hold);
            check("cont_trig_len", tl, 4);
            check("cont_event_wr", ev, 1);
            check("cont_data", data, 2);
        end

        // FIFO full: every result dropped, counter saturates at 255.
        full    = 1'b1;
        n_wr    = 0;
        n_drop  = 0;
        n_after = 0;
        for (int i = 0; i < 300; i++) begin
            measure(1'b0, 1, tl, lat, ev, data, after, hold);
            if (ev == 1) n_wr++;
            if (ev == 2) n_drop++;
            if (after) n_after++;
            if (i == 0) check("full_first_drop_cnt", drop_cnt, 1);
        end
        check("full_drop_pulses", n_drop, 300);
        check("full_no_writes", n_wr, 0);
        check("full_pulse_width", n_after, 0);
        check("full_drop_cnt_sat", drop_cnt, 255);

        // Reset during MEASURE: outputs clear next cycle, no write follows.
        b = 0;
        while (!trig && b < 50) begin
            tick();
            b++;
        end
        b = 0;
        while (trig && b < 20) begin
            tick();
            b++;
        end
        echo = 1'b1;
        repeat (10) tick();
        rs = 1'b1;
        tick();
        check("rs_trig", trig, 0);
        check("rs_busy", busy, 0);
        check("rs_drop_cnt", drop_cnt, 0);
        check("rs_wr", wr, 0);
        rs   = 1'b0;
        en   = 1'b0;
        full = 1'b0;
        echo = 1'b0;
        n_wr = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wr || drop || busy) n_wr++;
        end
        check("rs_no_activity", n_wr, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
